// File: rtl/decomp_pkg.sv
// Shared types and defaults for the PC change detector in the decompressor front end.
// Contents:
//   PCD_WIDTH_DEFAULT  default PC width in bits
//   PCD_CNT_W_DEFAULT  default width of the saturating stable-PC counter
//   pcd_state_t        request FSM state encoding
package decomp_pkg;

  localparam int unsigned PCD_WIDTH_DEFAULT = 32;
  localparam int unsigned PCD_CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    IDLE     = 2'd1,
    REQ      = 2'd2,
    REQ_PEND = 2'd3
  } pcd_state_t;

endpackage

// File: rtl/pc_change_detector_if.sv
// Bus between the PC source / fetch stage and the PC change detector.
// Signals:
//   pc_i, pc_valid_i, flush_i  incoming PC stream (source -> detector)
//   req_valid_o, req_pc_o      fetch request (detector -> fetch)
//   req_ready_i                fetch accepts request (fetch -> detector)
//   equal_o, same_cnt_o        PC stability status (detector -> observers)
//   dropped_o                  pending PC overwritten pulse (detector -> observers)
// Modports: master = environment side, slave = detector side.
interface pc_change_detector_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) ();

  logic [WIDTH-1:0] pc_i;
  logic             pc_valid_i;
  logic             flush_i;
  logic             req_valid_o;
  logic [WIDTH-1:0] req_pc_o;
  logic             req_ready_i;
  logic             equal_o;
  logic [CNT_W-1:0] same_cnt_o;
  logic             dropped_o;

  modport master (
    output pc_i,
    output pc_valid_i,
    output flush_i,
    output req_ready_i,
    input  req_valid_o,
    input  req_pc_o,
    input  equal_o,
    input  same_cnt_o,
    input  dropped_o
  );

  modport slave (
    input  pc_i,
    input  pc_valid_i,
    input  flush_i,
    input  req_ready_i,
    output req_valid_o,
    output req_pc_o,
    output equal_o,
    output same_cnt_o,
    output dropped_o
  );

endinterface

// File: rtl/pc_change_detector_word_eq.sv
// Pure combinational full-width equality cell.
// Ports:
//   a, b  words to compare
//   eq    1 when a == b
module word_eq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq
);

  assign eq = (a == b);

endmodule

// File: rtl/pc_change_detector.sv
// Registered PC change detector: samples the PC stream, issues a valid/ready fetch
// request for every new PC, buffers one pending PC while a request is stalled, and
// counts how long the PC has been stable.
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    slave side of pc_change_detector_if (PC stream in, fetch request out,
//          equal/same_cnt/dropped status out)
module pc_change_detector
  import decomp_pkg::*;
#(
  parameter int unsigned WIDTH = PCD_WIDTH_DEFAULT,
  parameter int unsigned CNT_W = PCD_CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pc_change_detector_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pcd_state_t       state_q;
  pcd_state_t       state_d;
  logic [WIDTH-1:0] last_pc_q;
  logic [WIDTH-1:0] pend_pc_q;
  logic [WIDTH-1:0] pend_pc_d;
  logic [WIDTH-1:0] req_pc_q;
  logic [WIDTH-1:0] req_pc_d;
  logic             req_valid_q;
  logic             equal_q;
  logic [CNT_W-1:0] same_cnt_q;
  logic             dropped_q;
  logic             dropped_d;

  logic             pc_eq;
  logic             change;
  logic             hs;

  // Single equality comparator: incoming PC vs last sampled PC.
  word_eq #(
    .WIDTH (WIDTH)
  ) u_pc_eq (
    .a  (bus.pc_i),
    .b  (last_pc_q),
    .eq (pc_eq)
  );

  // EMPTY forces the first valid PC after reset to count as a change.
  assign change = bus.pc_valid_i && ((state_q == EMPTY) || !pc_eq || bus.flush_i);
  assign hs     = req_valid_q && bus.req_ready_i;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (change) state_d = REQ;
      end
      IDLE: begin
        if (change) state_d = REQ;
      end
      REQ: begin
        if (hs && !change)      state_d = IDLE;
        else if (!hs && change) state_d = REQ_PEND;
      end
      REQ_PEND: begin
        if (hs && !change) state_d = REQ;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Output / datapath next values: request PC, pending PC, drop pulse.
  always_comb begin
    req_pc_d  = req_pc_q;
    pend_pc_d = pend_pc_q;
    dropped_d = 1'b0;
    unique case (state_q)
      EMPTY, IDLE: begin
        if (change) req_pc_d = bus.pc_i;
      end
      REQ: begin
        if (hs && change)       req_pc_d  = bus.pc_i;
        else if (!hs && change) pend_pc_d = bus.pc_i;
      end
      REQ_PEND: begin
        if (hs) begin
          req_pc_d = pend_pc_q;
          if (change) pend_pc_d = bus.pc_i;
        end else if (change) begin
          // Newest PC wins; the older pending one is lost.
          pend_pc_d = bus.pc_i;
          dropped_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs, PC history and stability counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_pc_q   <= '0;
      pend_pc_q   <= '0;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
      equal_q     <= 1'b0;
      same_cnt_q  <= '0;
      dropped_q   <= 1'b0;
    end else begin
      req_pc_q    <= req_pc_d;
      pend_pc_q   <= pend_pc_d;
      dropped_q   <= dropped_d;
      req_valid_q <= (state_d == REQ) || (state_d == REQ_PEND);
      if (bus.pc_valid_i) begin
        last_pc_q <= bus.pc_i;
        equal_q   <= !change;
        if (change) begin
          same_cnt_q <= '0;
        end else if (same_cnt_q != CNT_MAX) begin
          same_cnt_q <= same_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.req_valid_o = req_valid_q;
  assign bus.req_pc_o    = req_pc_q;
  assign bus.equal_o     = equal_q;
  assign bus.same_cnt_o  = same_cnt_q;
  assign bus.dropped_o   = dropped_q;

endmodule

// File: tb/tb_pc_change_detector.sv
// Directed self-checking bench for pc_change_detector.
module tb_pc_change_detector;
  import decomp_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 8;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic saw_req;

  pc_change_detector_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  pc_change_detector #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [31:0] pc,
                         input logic eq, input logic [7:0] cnt, input logic drp);
    chk({tag, ".req_valid"}, 32'(bus.req_valid_o), 32'(vld));
    chk({tag, ".req_pc"},    bus.req_pc_o,          pc);
    chk({tag, ".equal"},     32'(bus.equal_o),      32'(eq));
    chk({tag, ".same_cnt"},  32'(bus.same_cnt_o),   32'(cnt));
    chk({tag, ".dropped"},   32'(bus.dropped_o),    32'(drp));
  endtask

  task automatic drive(input logic vld, input logic [31:0] pc, input logic fl, input logic rdy);
    bus.pc_valid_i  = vld;
    bus.pc_i        = pc;
    bus.flush_i     = fl;
    bus.req_ready_i = rdy;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    saw_req = 1'b0;
    rst_n   = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);

    // Reset state
    tick(); tick();
    chk_out("reset", 1'b0, 32'h0, 1'b0, 8'd0, 1'b0);
    rst_n = 1'b1;

    // 1: first valid PC always fetches, accepted immediately
    drive(1'b1, 32'h100, 1'b0, 1'b1);
    tick();
    chk_out("t1_req", 1'b1, 32'h100, 1'b0, 8'd0, 1'b0);
    tick();
    chk_out("t1_done", 1'b0, 32'h100, 1'b1, 8'd1, 1'b0);

    // 2: hold the same PC; counter saturates at 255, no requests
    for (int i = 0; i < 253; i++) begin
      tick();
      if (bus.req_valid_o) saw_req = 1'b1;
    end
    chk("t2_cnt254", 32'(bus.same_cnt_o), 32'd254);
    tick();
    chk("t2_cnt255", 32'(bus.same_cnt_o), 32'd255);
    for (int i = 0; i < 46; i++) begin
      tick();
      if (bus.req_valid_o) saw_req = 1'b1;
    end
    chk_out("t2_sat", 1'b0, 32'h100, 1'b1, 8'd255, 1'b0);
    chk("t2_no_req", 32'(saw_req), 32'd0);

    // 3: stalled fetch, pending PC overwritten
    drive(1'b1, 32'h200, 1'b0, 1'b0);
    tick();
    chk_out("t3_200", 1'b1, 32'h200, 1'b0, 8'd0, 1'b0);
    drive(1'b1, 32'h204, 1'b0, 1'b0);
    tick();
    chk_out("t3_204", 1'b1, 32'h200, 1'b0, 8'd0, 1'b0);
    drive(1'b1, 32'h208, 1'b0, 1'b0);
    tick();
    chk_out("t3_208", 1'b1, 32'h200, 1'b0, 8'd0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    chk_out("t3_hold", 1'b1, 32'h200, 1'b0, 8'd0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    chk_out("t3_pend_issue", 1'b1, 32'h208, 1'b0, 8'd0, 1'b0);
    tick();
    chk_out("t3_idle", 1'b0, 32'h208, 1'b0, 8'd0, 1'b0);

    // 4: back-to-back request on handshake plus change
    drive(1'b1, 32'h2F0, 1'b0, 1'b1);
    tick();
    chk_out("t4_2f0", 1'b1, 32'h2F0, 1'b0, 8'd0, 1'b0);
    drive(1'b1, 32'h300, 1'b0, 1'b1);
    tick();
    chk_out("t4_300", 1'b1, 32'h300, 1'b0, 8'd0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    chk_out("t4_idle", 1'b0, 32'h300, 1'b0, 8'd0, 1'b0);

    // 5: flush on an equal PC refetches; wrap-around is a change
    drive(1'b1, 32'h400, 1'b0, 1'b1);
    tick();
    chk_out("t5_400", 1'b1, 32'h400, 1'b0, 8'd0, 1'b0);
    tick();
    chk_out("t5_eq1", 1'b0, 32'h400, 1'b1, 8'd1, 1'b0);
    tick();
    chk_out("t5_eq2", 1'b0, 32'h400, 1'b1, 8'd2, 1'b0);
    drive(1'b1, 32'h400, 1'b1, 1'b1);
    tick();
    chk_out("t5_flush", 1'b1, 32'h400, 1'b0, 8'd0, 1'b0);
    drive(1'b1, 32'h400, 1'b0, 1'b1);
    tick();
    chk_out("t5_after", 1'b0, 32'h400, 1'b1, 8'd1, 1'b0);
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    tick();
    chk_out("t5_fffc", 1'b1, 32'hFFFF_FFFC, 1'b0, 8'd0, 1'b0);
    drive(1'b1, 32'h0, 1'b0, 1'b1);
    tick();
    chk_out("t5_wrap", 1'b1, 32'h0, 1'b0, 8'd0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    chk_out("t5_nv_flush1", 1'b0, 32'h0, 1'b0, 8'd0, 1'b0);
    tick();
    chk_out("t5_nv_flush2", 1'b0, 32'h0, 1'b0, 8'd0, 1'b0);

    // 6: reset mid-handshake abandons the request
    drive(1'b1, 32'h500, 1'b0, 1'b0);
    tick();
    chk_out("t6_500", 1'b1, 32'h500, 1'b0, 8'd0, 1'b0);
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    chk_out("t6_rst", 1'b0, 32'h0, 1'b0, 8'd0, 1'b0);
    rst_n = 1'b1;
    // PC equals reset last_pc but EMPTY still forces a request
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    tick();
    chk_out("t6_first", 1'b1, 32'h0, 1'b0, 8'd0, 1'b0);
    tick();
    chk_out("t6_stall", 1'b1, 32'h0, 1'b1, 8'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
